// File: rtl/chord_bus_pkg.sv
// Shared encodings for the CHORD AHB-Lite FIFO bridge: bus codes, register map,
// STATUS/CTRL bit positions and the data-phase FSM state type.
package chord_bus_pkg;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_CTRL     = 2'd2;
  localparam logic [1:0] REG_UNMAPPED = 2'd3;

  localparam int ST_TX_OVF   = 0;
  localparam int ST_RX_UNF   = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_CNT   = 8;
  localparam int ST_RX_CNT   = 16;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_RX_THR = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1
  } ahb_state_e;

  // Address-phase attributes carried into the data phase.
  typedef struct packed {
    logic [1:0] off;
    logic       write;
    logic       size_ok;
  } aph_t;

  typedef struct packed {
    logic [7:0] rx_thr;
    logic       irq_en;
  } ctrl_t;

  function automatic logic is_xfer(input logic hsel, input logic hready, input logic [1:0] htrans);
    return hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
  endfunction

endpackage

// File: rtl/chord_ahb_fifo_bridge_if.sv
// AHB-Lite slave bus plus the two core-side streams of the CHORD FIFO bridge.
// slave = bridge view; master = bus master / core view.
interface chord_ahb_fifo_bridge_if #(
  parameter int WIDTH = 32
);
  logic             HSEL;
  logic             HWRITE;
  logic             HREADY;
  logic             HMASTLOCK;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic [2:0]       HSIZE;
  logic [2:0]       HBURST;
  logic [3:0]       HPROT;
  logic [31:0]      HWDATA;
  logic [31:0]      HRDATA;
  logic             HREADYOUT;
  logic [1:0]       HRESP;
  logic             INTR;

  logic [WIDTH-1:0] out_interface;
  logic             valid_out_interface;
  logic             ready_out_interface;
  logic [WIDTH-1:0] in_interface;
  logic             valid_in_interface;
  logic             ready_in_interface;

  modport slave (
    input  HSEL, HWRITE, HREADY, HMASTLOCK, HADDR, HTRANS, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HREADYOUT, HRESP, INTR,
    output out_interface, valid_out_interface,
    input  ready_out_interface,
    input  in_interface, valid_in_interface,
    output ready_in_interface
  );

  modport master (
    output HSEL, HWRITE, HREADY, HMASTLOCK, HADDR, HTRANS, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADYOUT, HRESP, INTR,
    input  out_interface, valid_out_interface,
    output ready_out_interface,
    output in_interface, valid_in_interface,
    input  ready_in_interface
  );

endinterface

// File: rtl/chord_sync_fifo.sv
// Synchronous FIFO, power-of-two DEPTH; registered count, head readable combinationally.
// Push ignored when full, pop ignored when empty; simultaneous push+pop keeps count.
module chord_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/chord_ahb_fifo_bridge.sv
// AHB-Lite slave bridging the bus to the CHORD core via TX/RX FIFOs, with status/ctrl and INTR.
// Zero-wait OKAY, two-cycle ERROR; core streams backpressured by FIFO full/empty.
module chord_ahb_fifo_bridge
  import chord_bus_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int WIDTH    = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  chord_ahb_fifo_bridge_if.slave  bus
);

  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;

  ahb_state_e       state, state_nxt;
  aph_t             aph, aph_nxt;
  ctrl_t            ctrl;
  logic             tx_ovf, rx_unf, intr;

  logic [WIDTH-1:0] tx_head, rx_head;
  logic [TXCW-1:0]  tx_count;
  logic [RXCW-1:0]  rx_count;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic             tx_push, tx_pop, rx_push, rx_pop;

  logic             off_data, tx_ovf_hit, rx_unf_hit, dp_err, err_cycle1;
  logic             st_wr, ctrl_wr, sample, accept;
  logic [7:0]       rx_cnt8;
  logic [31:0]      status_word, ctrl_word, hrdata;
  logic             irq_cond;
  logic             unused_ok;

  chord_sync_fifo #(.WIDTH(WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (tx_push),
    .push_data (bus.HWDATA[WIDTH-1:0]),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  chord_sync_fifo #(.WIDTH(WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (rx_push),
    .push_data (bus.in_interface),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Core side: flags from registered counts only.
  assign bus.valid_out_interface = ~tx_empty;
  assign bus.ready_in_interface  = ~rx_full;
  assign bus.out_interface       = tx_empty ? '0 : tx_head;
  assign tx_pop  = bus.valid_out_interface & bus.ready_out_interface;
  assign rx_push = bus.valid_in_interface & bus.ready_in_interface;

  assign accept = is_xfer(bus.HSEL, bus.HREADY, bus.HTRANS);

  // Error classification uses counts as they stand at the start of the data phase.
  always_comb begin
    off_data   = (aph.off == REG_DATA);
    tx_ovf_hit = aph.size_ok & off_data & aph.write & tx_full;
    rx_unf_hit = aph.size_ok & off_data & ~aph.write & rx_empty;
    dp_err     = ~aph.size_ok | (aph.off == REG_UNMAPPED) | tx_ovf_hit | rx_unf_hit;
  end

  assign err_cycle1    = (state == ST_DATA) & dp_err;
  assign bus.HREADYOUT = ~err_cycle1;
  assign bus.HRESP     = (err_cycle1 | (state == ST_ERR1)) ? HRESP_ERROR : HRESP_OKAY;

  always_comb begin
    state_nxt = state;
    aph_nxt   = aph;
    tx_push   = 1'b0;
    rx_pop    = 1'b0;
    st_wr     = 1'b0;
    ctrl_wr   = 1'b0;
    sample    = 1'b0;
    case (state)
      ST_IDLE: sample = 1'b1;
      ST_DATA: begin
        if (dp_err) begin
          state_nxt = ST_ERR1;
        end else begin
          sample  = 1'b1;
          tx_push = off_data & aph.write;
          rx_pop  = off_data & ~aph.write;
          st_wr   = (aph.off == REG_STATUS) & aph.write;
          ctrl_wr = (aph.off == REG_CTRL) & aph.write;
        end
      end
      ST_ERR1: sample = 1'b1;
      default: state_nxt = ST_IDLE;
    endcase
    if (sample) begin
      if (accept) begin
        state_nxt       = ST_DATA;
        aph_nxt.off     = bus.HADDR[3:2];
        aph_nxt.write   = bus.HWRITE;
        aph_nxt.size_ok = (bus.HSIZE == HSIZE_WORD);
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      aph   <= '0;
    end else begin
      state <= state_nxt;
      aph   <= aph_nxt;
    end
  end

  assign rx_cnt8  = 8'(rx_count);
  assign irq_cond = ctrl.irq_en &
                    (((ctrl.rx_thr != 8'd0) & (rx_cnt8 >= ctrl.rx_thr)) | tx_ovf | rx_unf);

  // Sticky flags: error sets are OR-ed after the W1C mask so a set always wins.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
      ctrl   <= '0;
      intr   <= 1'b0;
    end else begin
      tx_ovf <= (tx_ovf & ~(st_wr & bus.HWDATA[ST_TX_OVF])) | (err_cycle1 & tx_ovf_hit);
      rx_unf <= (rx_unf & ~(st_wr & bus.HWDATA[ST_RX_UNF])) | (err_cycle1 & rx_unf_hit);
      if (ctrl_wr) begin
        ctrl.irq_en <= bus.HWDATA[CTRL_IRQ_EN];
        ctrl.rx_thr <= bus.HWDATA[CTRL_RX_THR +: 8];
      end
      intr <= irq_cond;
    end
  end

  assign bus.INTR = intr;

  always_comb begin
    status_word                    = '0;
    status_word[ST_TX_OVF]         = tx_ovf;
    status_word[ST_RX_UNF]         = rx_unf;
    status_word[ST_TX_FULL]        = tx_full;
    status_word[ST_RX_EMPTY]       = rx_empty;
    status_word[ST_TX_CNT +: 8]    = 8'(tx_count);
    status_word[ST_RX_CNT +: 8]    = rx_cnt8;
    ctrl_word                      = '0;
    ctrl_word[CTRL_IRQ_EN]         = ctrl.irq_en;
    ctrl_word[CTRL_RX_THR +: 8]    = ctrl.rx_thr;
  end

  always_comb begin
    hrdata = '0;
    if ((state == ST_DATA) && !aph.write && !dp_err) begin
      case (aph.off)
        REG_DATA:   hrdata = 32'(rx_head);
        REG_STATUS: hrdata = status_word;
        REG_CTRL:   hrdata = ctrl_word;
        default:    hrdata = '0;
      endcase
    end
  end

  assign bus.HRDATA = hrdata;

  assign unused_ok = ^{bus.HMASTLOCK, bus.HBURST, bus.HPROT, bus.HADDR[31:4], bus.HADDR[1:0],
                       bus.HWDATA};

endmodule

// File: tb/tb_chord_ahb_fifo_bridge.sv
// Scoreboard bench for chord_ahb_fifo_bridge: single AHB transfers plus core-side stream traffic.
module tb_chord_ahb_fifo_bridge;
  import chord_bus_pkg::*;

  localparam int TX_DEPTH = 8;
  localparam int RX_DEPTH = 8;
  localparam int WIDTH    = 32;
  localparam int K_OKAY   = 0;
  localparam int K_ERROR  = 1;
  localparam int K_BAD    = 2;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  chord_ahb_fifo_bridge_if #(.WIDTH(WIDTH)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  chord_ahb_fifo_bridge #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .WIDTH(WIDTH)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] tx_q [$];
  logic [31:0] rx_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic ovf, input logic unf, input int txc, input int rxc);
    logic [31:0] s;
    s        = '0;
    s[0]     = ovf;
    s[1]     = unf;
    s[2]     = (txc == TX_DEPTH);
    s[3]     = (rxc == 0);
    s[15:8]  = txc[7:0];
    s[23:16] = rxc[7:0];
    return s;
  endfunction

  // TX scoreboard: compare every word the core accepts, a little before the accepting edge.
  always @(negedge HCLK) begin
    #3;
    if (HRESETn && bus.valid_out_interface && bus.ready_out_interface) begin
      if (tx_q.size() == 0) check_val("tx_unexpected_pop", 32'd1, 32'd0);
      else                  check_val("tx_pop", bus.out_interface, tx_q.pop_front());
    end
  end

  // One non-pipelined transfer; kind: OKAY, well-formed two-cycle ERROR, or BAD.
  task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wd, input logic cpush, input logic [31:0] cval,
                          output logic [31:0] rd, output int kind);
    logic       r1, r2;
    logic [1:0] p1, p2;
    @(negedge HCLK);
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    @(negedge HCLK);
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWDATA = wd;
    if (cpush) begin
      bus.valid_in_interface = 1'b1;
      bus.in_interface       = cval;
      rx_q.push_back(cval);
    end
    #1;
    r1 = bus.HREADYOUT;
    p1 = bus.HRESP;
    rd = bus.HRDATA;
    if (r1) begin
      kind = (p1 == HRESP_OKAY) ? K_OKAY : K_BAD;
    end else begin
      @(negedge HCLK);
      #1;
      r2 = bus.HREADYOUT;
      p2 = bus.HRESP;
      kind = (p1 == HRESP_ERROR && r2 && p2 == HRESP_ERROR) ? K_ERROR : K_BAD;
    end
    if (cpush) begin
      @(posedge HCLK);
      #1;
      bus.valid_in_interface = 1'b0;
    end
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] wd, output int kind);
    logic [31:0] d;
    ahb_xfer(1'b1, addr, HSIZE_WORD, wd, 1'b0, 32'd0, d, kind);
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] rd, output int kind);
    ahb_xfer(1'b0, addr, HSIZE_WORD, 32'd0, 1'b0, 32'd0, rd, kind);
  endtask

  task automatic core_push(input logic [31:0] v);
    @(negedge HCLK);
    check_val("rx_ready", {31'd0, bus.ready_in_interface}, 32'd1);
    bus.valid_in_interface = 1'b1;
    bus.in_interface       = v;
    rx_q.push_back(v);
  endtask

  task automatic core_idle();
    @(negedge HCLK);
    bus.valid_in_interface = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_hrdata"}, bus.HRDATA, 32'd0);
    check_val({tag, "_hreadyout"}, {31'd0, bus.HREADYOUT}, 32'd1);
    check_val({tag, "_hresp"}, {30'd0, bus.HRESP}, 32'd0);
    check_val({tag, "_intr"}, {31'd0, bus.INTR}, 32'd0);
    check_val({tag, "_valid_out"}, {31'd0, bus.valid_out_interface}, 32'd0);
    check_val({tag, "_ready_in"}, {31'd0, bus.ready_in_interface}, 32'd1);
    check_val({tag, "_out_data"}, bus.out_interface, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          k;
    logic [31:0] w;

    bus.HSEL = 1'b0;  bus.HWRITE = 1'b0;  bus.HMASTLOCK = 1'b0;
    bus.HADDR = '0;   bus.HTRANS = 2'b00; bus.HSIZE = HSIZE_WORD;
    bus.HBURST = '0;  bus.HPROT = '0;     bus.HWDATA = '0;
    bus.ready_out_interface = 1'b0;
    bus.valid_in_interface  = 1'b0;
    bus.in_interface        = '0;

    repeat (2) @(negedge HCLK);
    #1;
    check_reset_outputs("reset");
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Single write, core ready
    bus.ready_out_interface = 1'b1;
    tx_q.push_back(32'h0000_00A5);
    bus_wr(32'h0, 32'h0000_00A5, k);
    check_val("a5_resp", k, K_OKAY);
    @(negedge HCLK);
    check_val("a5_valid_out", {31'd0, bus.valid_out_interface}, 32'd1);
    check_val("a5_out_data", bus.out_interface, 32'h0000_00A5);
    bus_rd(32'h4, rd, k);
    check_val("a5_status_resp", k, K_OKAY);
    check_val("a5_status", rd, exp_status(1'b0, 1'b0, 0, 0));

    // Fill TX with the core stalled, then overflow
    bus.ready_out_interface = 1'b0;
    for (int i = 0; i < TX_DEPTH + 1; i++) begin
      w = 32'h1000_0000 + i;
      bus_wr(32'h0, w, k);
      if (i < TX_DEPTH) begin
        tx_q.push_back(w);
        check_val("fill_okay", k, K_OKAY);
      end else begin
        check_val("fill_overflow", k, K_ERROR);
      end
    end
    bus_rd(32'h4, rd, k);
    check_val("ovf_status", rd, exp_status(1'b1, 1'b0, TX_DEPTH, 0));
    check_val("ovf_intr_masked", {31'd0, bus.INTR}, 32'd0);
    bus_wr(32'h4, 32'h1, k);
    check_val("w1c_resp", k, K_OKAY);
    bus_rd(32'h4, rd, k);
    check_val("w1c_status", rd, exp_status(1'b0, 1'b0, TX_DEPTH, 0));
    bus.ready_out_interface = 1'b1;
    for (int c = 0; c < 4 * TX_DEPTH && tx_q.size() != 0; c++) @(negedge HCLK);
    check_val("tx_drained", tx_q.size(), 32'd0);
    @(negedge HCLK);
    check_val("tx_valid_low", {31'd0, bus.valid_out_interface}, 32'd0);

    // Read from empty RX
    bus_rd(32'h0, rd, k);
    check_val("unf_resp", k, K_ERROR);
    check_val("unf_hrdata", rd, 32'd0);
    bus_rd(32'h4, rd, k);
    check_val("unf_status", rd, exp_status(1'b0, 1'b1, 0, 0));
    bus_wr(32'h4, 32'h2, k);
    bus_rd(32'h4, rd, k);
    check_val("unf_cleared", rd, exp_status(1'b0, 1'b0, 0, 0));

    // Threshold interrupt
    bus_wr(32'h8, 32'h0000_0301, k);
    check_val("ctrl_wr_resp", k, K_OKAY);
    bus_rd(32'h8, rd, k);
    check_val("ctrl_readback", rd, 32'h0000_0301);
    core_push(32'h0000_00B1);
    core_push(32'h0000_00B2);
    core_push(32'h0000_00B3);
    core_idle();
    check_val("thr_intr_lag", {31'd0, bus.INTR}, 32'd0);
    @(negedge HCLK);
    check_val("thr_intr_rise", {31'd0, bus.INTR}, 32'd1);
    bus_rd(32'h4, rd, k);
    check_val("thr_status", rd, exp_status(1'b0, 1'b0, 0, 3));
    bus_rd(32'h0, rd, k);
    check_val("thr_rd_resp", k, K_OKAY);
    check_val("thr_rd", rd, rx_q.pop_front());
    @(negedge HCLK);
    check_val("thr_intr_hold", {31'd0, bus.INTR}, 32'd1);
    @(negedge HCLK);
    check_val("thr_intr_fall", {31'd0, bus.INTR}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      bus_rd(32'h0, rd, k);
      check_val("thr_rd", rd, rx_q.pop_front());
    end
    bus_wr(32'h8, 32'h0, k);

    // Simultaneous core push and bus pop at RX count 1, across pointer wrap
    core_push(32'hC000_0000);
    core_idle();
    for (int i = 0; i < 2 * RX_DEPTH; i++) begin
      ahb_xfer(1'b0, 32'h0, HSIZE_WORD, 32'd0, 1'b1, 32'hC000_0001 + i, rd, k);
      check_val("sim_resp", k, K_OKAY);
      check_val("sim_rd", rd, rx_q.pop_front());
    end
    bus_rd(32'h4, rd, k);
    check_val("sim_status", rd, exp_status(1'b0, 1'b0, 0, 1));
    bus_rd(32'h0, rd, k);
    check_val("sim_last_rd", rd, rx_q.pop_front());

    // Size and offset errors leave state untouched
    ahb_xfer(1'b1, 32'h8, 3'b000, 32'h0000_0301, 1'b0, 32'd0, rd, k);
    check_val("hsize_ctrl_resp", k, K_ERROR);
    ahb_xfer(1'b1, 32'h0, 3'b000, 32'h0000_0055, 1'b0, 32'd0, rd, k);
    check_val("hsize_data_resp", k, K_ERROR);
    bus_wr(32'hC, 32'hFFFF_FFFF, k);
    check_val("off3_wr_resp", k, K_ERROR);
    bus_rd(32'hC, rd, k);
    check_val("off3_rd_resp", k, K_ERROR);
    check_val("off3_rd_data", rd, 32'd0);
    bus_rd(32'h8, rd, k);
    check_val("err_ctrl_unchanged", rd, 32'd0);
    bus_rd(32'h4, rd, k);
    check_val("err_status_unchanged", rd, exp_status(1'b0, 1'b0, 0, 0));

    // Reset in the middle of an ERROR response
    bus_wr(32'h8, 32'h1, k);
    bus_rd(32'h0, rd, k);
    @(negedge HCLK);
    check_val("pre_rst_intr", {31'd0, bus.INTR}, 32'd1);
    bus.ready_out_interface = 1'b0;
    bus_wr(32'h0, 32'h0000_0077, k);
    @(negedge HCLK);
    check_val("pre_rst_valid_out", {31'd0, bus.valid_out_interface}, 32'd1);
    @(negedge HCLK);
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HADDR = 32'h0;
    bus.HWRITE = 1'b0; bus.HSIZE = HSIZE_WORD;
    @(negedge HCLK);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    #1;
    check_val("mid_err_cycle1", {31'd0, bus.HREADYOUT}, 32'd0);
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("mid_err_rst");
    @(negedge HCLK);
    HRESETn = 1'b1;
    bus_rd(32'h4, rd, k);
    check_val("post_rst_status", rd, exp_status(1'b0, 1'b0, 0, 0));
    bus_rd(32'h8, rd, k);
    check_val("post_rst_ctrl", rd, 32'd0);

    check_val("tx_q_empty", tx_q.size(), 32'd0);
    check_val("rx_q_empty", rx_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
